// File: rtl/global_avg_pool_pkg.sv
// Shared types and constants for the global average pool and its helpers.
package avg_pool_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_NEAREST = 1;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/global_avg_pool_chk.sv
// Checker for the pool's divider results: the quotient must fit the output
// width and the remainder must be a proper remainder.
module global_avg_pool_chk #(
    parameter int ACC_WIDTH  = 39,
    parameter int DATA_WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset_n,
    input logic                 done,
    input logic [ACC_WIDTH-1:0] quotient,
    input logic [ACC_WIDTH-1:0] remainder,
    input logic [ACC_WIDTH-1:0] divisor
);

    a_quot_fits: assert property (@(posedge clock) disable iff (!reset_n)
        done |-> (quotient[ACC_WIDTH-1:DATA_WIDTH] == {(ACC_WIDTH-DATA_WIDTH){1'b0}}));

    a_rem_proper: assert property (@(posedge clock) disable iff (!reset_n)
        done |-> (remainder < divisor));

endmodule

// File: rtl/global_avg_pool_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done arrives WIDTH cycles after start.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_rem_in;
    logic [WIDTH-1:0] w_quot_in;
    logic [WIDTH-1:0] w_divisor;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    // One restoring step, seeded from the ports on the start cycle.
    always_comb begin
        w_rem_in  = r_rem;
        w_quot_in = r_quot;
        w_divisor = r_divisor;
        if (start) begin
            w_rem_in  = {WIDTH{1'b0}};
            w_quot_in = dividend;
            w_divisor = divisor;
        end else begin
            w_rem_in  = r_rem;
            w_quot_in = r_quot;
            w_divisor = r_divisor;
        end
        w_shift = {w_rem_in, w_quot_in[WIDTH-1]};
        w_trial = w_shift - {1'b0, w_divisor};
        if (w_trial[WIDTH]) begin
            w_rem_nxt  = w_shift[WIDTH-1:0];
            w_quot_nxt = {w_quot_in[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_nxt  = w_trial[WIDTH-1:0];
            w_quot_nxt = {w_quot_in[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration state; abort drops any division in flight without a done.
    always_ff @(posedge clock) begin
        if (!reset_n || abort) begin
            r_rem     <= {WIDTH{1'b0}};
            r_quot    <= {WIDTH{1'b0}};
            r_divisor <= {WIDTH{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_rem     <= w_rem_nxt;
            r_quot    <= w_quot_nxt;
            r_divisor <= divisor;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_busy    <= (WIDTH > 1);
            r_done    <= (WIDTH == 1);
        end else if (r_busy) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule

// File: rtl/global_avg_pool.sv
// Multi-channel global average pool: accumulates a channel-interleaved frame,
// then divides each channel sum by the point count with one shared divider.
module global_avg_pool
    import avg_pool_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_POINTS   = 49,
    parameter int NUM_CHANNELS = 4,
    parameter int ROUND_MODE   = 0,
    parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(NUM_POINTS) + 1,
    parameter int CH_W         = idx_width(NUM_CHANNELS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_channel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int PT_W = idx_width(NUM_POINTS);
    localparam logic [ACC_WIDTH-1:0] DIVISOR = ACC_WIDTH'(NUM_POINTS);
    localparam logic [ACC_WIDTH-1:0] BIAS =
        (ROUND_MODE == ROUND_NEAREST) ? ACC_WIDTH'(NUM_POINTS / 2) : {ACC_WIDTH{1'b0}};

    state_e                r_state;
    logic [ACC_WIDTH-1:0]  r_acc [NUM_CHANNELS];
    logic [CH_W-1:0]       r_ch;
    logic [PT_W-1:0]       r_pt;
    logic                  r_start;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]       r_out_channel;
    logic                  r_out_last;

    logic [ACC_WIDTH-1:0]  w_dividend;
    logic [ACC_WIDTH-1:0]  w_div_quot;
    logic [ACC_WIDTH-1:0]  w_div_rem;
    logic                  w_div_done;
    logic                  w_last_ch;
    logic                  w_last_pt;

    assign w_last_ch  = (r_ch == CH_W'(NUM_CHANNELS - 1));
    assign w_last_pt  = (r_pt == PT_W'(NUM_POINTS - 1));
    assign w_dividend = r_acc[r_ch] + BIAS;

    seq_divider #(
        .WIDTH (ACC_WIDTH)
    ) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .abort     (clear),
        .start     (r_start),
        .dividend  (w_dividend),
        .divisor   (DIVISOR),
        .quotient  (w_div_quot),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    global_avg_pool_chk #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clock     (clock),
        .reset_n   (reset_n),
        .done      (w_div_done),
        .quotient  (w_div_quot),
        .remainder (w_div_rem),
        .divisor   (DIVISOR)
    );

    // Frame FSM: accumulate, then divide/emit one channel at a time.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_state       <= ST_ACCUM;
            r_ch          <= {CH_W{1'b0}};
            r_pt          <= {PT_W{1'b0}};
            r_start       <= 1'b0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= {DATA_WIDTH{1'b0}};
            r_out_channel <= {CH_W{1'b0}};
            r_out_last    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_acc[i] <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc[r_ch] <= r_acc[r_ch] + ACC_WIDTH'(in_data);
                        if (w_last_ch) begin
                            r_ch <= {CH_W{1'b0}};
                            if (w_last_pt) begin
                                r_pt       <= {PT_W{1'b0}};
                                r_state    <= ST_DIVIDE;
                                r_start    <= 1'b1;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b1;
                            end else begin
                                r_pt <= r_pt + PT_W'(1);
                            end
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_div_done) begin
                        r_out_data    <= w_div_quot[DATA_WIDTH-1:0];
                        r_out_channel <= r_ch;
                        r_out_last    <= w_last_ch;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_ch) begin
                            r_ch       <= {CH_W{1'b0}};
                            r_pt       <= {PT_W{1'b0}};
                            r_state    <= ST_ACCUM;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                r_acc[i] <= {ACC_WIDTH{1'b0}};
                            end
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= ST_DIVIDE;
                            r_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;
    assign out_last    = r_out_last;

endmodule

// File: tb/tb_global_avg_pool.sv
// Directed bench: default 49x4 pool plus two 4-point single-channel pools
// (truncate and round-half-up) driven in lockstep.
module tb_global_avg_pool;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        clear;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_channel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [31:0] s_in_data;
    logic        s_in_valid;
    logic        s_out_ready;
    logic        s0_in_ready, s1_in_ready;
    logic [31:0] s0_out_data, s1_out_data;
    logic [0:0]  s0_out_channel, s1_out_channel;
    logic        s0_out_last, s1_out_last;
    logic        s0_out_valid, s1_out_valid;
    logic        s0_busy, s1_busy;

    int n_checks = 0;
    int n_errors = 0;

    global_avg_pool u_dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_channel(out_channel), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    global_avg_pool #(.NUM_POINTS(4), .NUM_CHANNELS(1), .ROUND_MODE(0)) u_s0 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s0_in_ready),
        .out_data(s0_out_data), .out_channel(s0_out_channel), .out_last(s0_out_last),
        .out_valid(s0_out_valid), .out_ready(s_out_ready), .busy(s0_busy)
    );

    global_avg_pool #(.NUM_POINTS(4), .NUM_CHANNELS(1), .ROUND_MODE(1)) u_s1 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s1_in_ready),
        .out_data(s1_out_data), .out_channel(s1_out_channel), .out_last(s1_out_last),
        .out_valid(s1_out_valid), .out_ready(s_out_ready), .busy(s1_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_channel", {62'd0, out_channel}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
    endtask

    // Full or partial frame into the default pool; pattern k*100+p or a constant.
    task automatic send_frame(input bit use_const, input logic [31:0] cval, input int npts);
        int stalls;
        stalls = 0;
        for (int p = 0; p < npts; p++) begin
            for (int k = 0; k < 4; k++) begin
                in_data  = use_const ? cval : 32'(k * 100 + p);
                in_valid = 1'b1;
                if (in_ready !== 1'b1) stalls++;
                tick();
            end
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        chk("in_stalls", 64'(stalls), 64'd0);
    endtask

    task automatic get_avg(input int ch, input logic [31:0] exp, input int hold);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
        chk("latency", 64'(cyc), 64'd40);
        chk("out_data", {32'd0, out_data}, {32'd0, exp});
        chk("out_channel", {62'd0, out_channel}, 64'(ch));
        chk("out_last", {63'd0, out_last}, (ch == 3) ? 64'd1 : 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_data", {32'd0, out_data}, {32'd0, exp});
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
        if (ch == 3) begin
            in_valid = 1'b0;
            chk("in_ready_after_last", {63'd0, in_ready}, 64'd1);
            chk("busy_after_last", {63'd0, busy}, 64'd0);
        end else begin
            chk("busy_between", {63'd0, busy}, 64'd1);
        end
    endtask

    task automatic send_small(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            s_in_data  = v[i];
            s_in_valid = 1'b1;
            tick();
        end
        s_in_valid = 1'b0;
    endtask

    task automatic get_small(input logic [31:0] exp_trunc, input logic [31:0] exp_round);
        int cyc;
        cyc = 0;
        while (s0_out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("s_valid_seen", {62'd0, s0_out_valid, s1_out_valid}, 64'd3);
        chk("s_latency", 64'(cyc), 64'd36);
        chk("s_trunc_data", {32'd0, s0_out_data}, {32'd0, exp_trunc});
        chk("s_round_data", {32'd0, s1_out_data}, {32'd0, exp_round});
        chk("s_last_chan", {60'd0, s0_out_last, s1_out_last, s0_out_channel, s1_out_channel}, 64'hC);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("s_valid_drop", {62'd0, s0_out_valid, s1_out_valid}, 64'd0);
        chk("s_in_ready", {62'd0, s0_in_ready, s1_in_ready}, 64'd3);
    endtask

    initial begin
        int seen_valid;
        reset_n     = 1'b0;
        clear       = 1'b0;
        in_data     = 32'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        s_in_data   = 32'd0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        tick();
        tick();
        chk_reset_state();
        chk("s_rst", {60'd0, s0_out_valid, s1_out_valid, s0_in_ready, s1_in_ready}, 64'd3);
        reset_n = 1'b1;
        tick();

        // Ramp pattern: averages 24/124/224/324.
        send_frame(1'b0, 32'd0, 49);
        get_avg(0, 32'd24, 0);
        get_avg(1, 32'd124, 0);
        get_avg(2, 32'd224, 0);
        get_avg(3, 32'd324, 0);

        // Full-scale samples.
        send_frame(1'b1, 32'hFFFF_FFFF, 49);
        for (int k = 0; k < 4; k++) get_avg(k, 32'hFFFF_FFFF, 0);

        // Output back-pressure with in_valid held high and junk on in_data.
        send_frame(1'b1, 32'd5, 49);
        in_valid = 1'b1;
        in_data  = 32'd999;
        for (int k = 0; k < 4; k++) get_avg(k, 32'd5, 10);
        send_frame(1'b0, 32'd0, 49);
        get_avg(0, 32'd24, 0);
        get_avg(1, 32'd124, 0);
        get_avg(2, 32'd224, 0);
        get_avg(3, 32'd324, 0);

        // Clear after 20 points, then a clean frame of 7s.
        send_frame(1'b1, 32'd1000, 20);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
        chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
        send_frame(1'b1, 32'd7, 49);
        for (int k = 0; k < 4; k++) get_avg(k, 32'd7, 0);

        // Reset pulse in the middle of a division.
        send_frame(1'b1, 32'd9, 49);
        repeat (10) tick();
        chk("mid_div_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_state();
        seen_valid = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid !== 1'b0) seen_valid++;
            tick();
        end
        chk("no_partial_output", 64'(seen_valid), 64'd0);
        send_frame(1'b1, 32'd3, 49);
        for (int k = 0; k < 4; k++) get_avg(k, 32'd3, 0);

        // Four-point single-channel pools, truncate vs round-half-up.
        send_small(32'd1, 32'd2, 32'd2, 32'd2);
        get_small(32'd1, 32'd2);
        send_small(32'd1, 32'd1, 32'd1, 32'd1);
        get_small(32'd1, 32'd1);
        send_small(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        get_small(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
